fpu_mul_sequencer: RTL and testbench

- Shares one single-precision multiplier core between two requesters: round-robin arbitration, operand capture and a programmable multicycle wait.
- Returns a packed IEEE-754 result with its requester ID through a valid/ready handshake.
- Keeps sticky exception flags.
- Sits between the FPU issue logic and the combinational multiplier core. The core is external and connected through the core_* ports.

---
 rtl/fpu_mul_pkg.sv | 26 ++
 rtl/fpu_rr_arb2.sv | 38 +++
 rtl/fpu_mul_sequencer.sv | 153 +++++++++++++++
 tb/tb_fpu_mul_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// rtl/fpu_mul_pkg.sv - shared encodings and field widths for the multiplier sequencer
package fpu_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_INV = 4;
    localparam int FLAG_OVF = 3;
    localparam int FLAG_UDF = 2;
    localparam int FLAG_INX = 1;
    localparam int FLAG_ZER = 0;
    localparam int FLAG_W   = 5;

    localparam int E_W = 8;
    localparam int M_W = 23;

    function automatic logic [E_W+M_W:0] pack_float(input logic           s,
                                                    input logic [E_W-1:0] e,
                                                    input logic [M_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// rtl/fpu_rr_arb2.sv - two-input round-robin arbiter, combinational grant, pointer moves on accept
module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o,
    output logic       accept_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_id_o = 1'b0;
        if (req_i == 2'b11) begin
            gnt_id_o = ptr_q;
        end else if (req_i[1]) begin
            gnt_id_o = 1'b1;
        end
        accept_o = en_i && (req_i != 2'b00);
        gnt_o    = 2'b00;
        if (accept_o) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
        // The loser of this round gets priority next time.
        ptr_d = accept_o ? ~gnt_id_o : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_mul_sequencer.sv
// rtl/fpu_mul_sequencer.sv - shares one multicycle fp multiplier core between two requesters
module fpu_mul_sequencer
    import fpu_mul_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_rmode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_rmode,
    output logic [31:0] core_opa,
    output logic [31:0] core_opb,
    output logic [1:0]  core_rmode,
    output logic [1:0]  core_en,
    input  logic        core_Sz,
    input  logic [7:0]  core_Ez,
    input  logic [23:0] core_Mz,
    input  logic [4:0]  core_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_z,
    output logic        res_id,
    output logic [4:0]  res_flags,
    output logic [4:0]  sticky_flags,
    input  logic        flag_clr
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic [1:0]         rmode_q, rmode_d, en_q, en_d;
    logic               id_q, id_d;
    logic               res_valid_q, res_valid_d, res_id_q, res_id_d;
    logic [31:0]        res_z_q, res_z_d;
    logic [FLAG_W-1:0]  res_flags_q, res_flags_d, sticky_q, sticky_d;
    logic [1:0]         gnt;
    logic               gnt_id, accept;
    logic               unused_hidden_bit;

    // The hidden bit is implied by the packed format and is not stored.
    assign unused_hidden_bit = core_Mz[M_W];

    fpu_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .en_i     (state_q == IDLE),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .accept_o (accept)
    );

    assign req0_ready   = gnt[0];
    assign req1_ready   = gnt[1];
    assign core_opa     = opa_q;
    assign core_opb     = opb_q;
    assign core_rmode   = rmode_q;
    assign core_en      = en_q;
    assign res_valid    = res_valid_q;
    assign res_z        = res_z_q;
    assign res_id       = res_id_q;
    assign res_flags    = res_flags_q;
    assign sticky_flags = sticky_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rmode_d     = rmode_q;
        en_d        = en_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_z_d     = res_z_q;
        res_id_d    = res_id_q;
        res_flags_d = res_flags_q;
        sticky_d    = flag_clr ? '0 : sticky_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d   = gnt_id ? req1_a : req0_a;
                    opb_d   = gnt_id ? req1_b : req0_b;
                    rmode_d = gnt_id ? req1_rmode : req0_rmode;
                    id_d    = gnt_id;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    en_d    = 2'b01;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_z_d     = pack_float(core_Sz, core_Ez, core_Mz[M_W-1:0]);
                    res_flags_d = core_flags;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    en_d        = 2'b00;
                    // Flags from a completing op survive a simultaneous clear.
                    sticky_d    = flag_clr ? core_flags : (sticky_q | core_flags);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rmode_q     <= '0;
            en_q        <= '0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_z_q     <= '0;
            res_id_q    <= 1'b0;
            res_flags_q <= '0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rmode_q     <= rmode_d;
            en_q        <= en_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_id_q    <= res_id_d;
            res_flags_q <= res_flags_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// tb/tb_fpu_mul_sequencer.sv - scoreboard bench for fpu_mul_sequencer with a truncating core model
module tb_fpu_mul_sequencer;

    localparam int LAT = 2;

    typedef struct packed {
        logic        id;
        logic [31:0] z;
        logic [4:0]  fl;
    } sb_entry_t;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_rmode, req1_rmode;
    logic [31:0] core_opa, core_opb;
    logic [1:0]  core_rmode, core_en;
    logic        core_Sz;
    logic [7:0]  core_Ez;
    logic [23:0] core_Mz;
    logic [4:0]  core_flags;
    logic        res_valid, res_ready, res_id, flag_clr;
    logic [31:0] res_z;
    logic [4:0]  res_flags, sticky_flags;

    logic        e_req0_valid, e_req0_ready, e_req1_ready;
    logic [31:0] e_req0_a, e_req0_b, e_core_opa, e_core_opb, e_res_z;
    logic [1:0]  e_core_rmode, e_core_en;
    logic        e_core_Sz, e_res_valid, e_res_id;
    logic [7:0]  e_core_Ez;
    logic [23:0] e_core_Mz;
    logic [4:0]  e_res_flags, e_sticky;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    sb_entry_t   sb[$];
    logic        acc_q[$];
    int          done_cyc[$];

    fpu_mul_sequencer #(.MUL_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_rmode(req0_rmode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_rmode(req1_rmode),
        .core_opa(core_opa), .core_opb(core_opb), .core_rmode(core_rmode), .core_en(core_en),
        .core_Sz(core_Sz), .core_Ez(core_Ez), .core_Mz(core_Mz), .core_flags(core_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_id(res_id),
        .res_flags(res_flags), .sticky_flags(sticky_flags), .flag_clr(flag_clr)
    );

    fpu_mul_sequencer #(.MUL_LAT(1), .CNT_W(4)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(e_req0_valid), .req0_ready(e_req0_ready), .req0_a(e_req0_a), .req0_b(e_req0_b),
        .req0_rmode(2'b00),
        .req1_valid(1'b0), .req1_ready(e_req1_ready), .req1_a(32'h0), .req1_b(32'h0),
        .req1_rmode(2'b00),
        .core_opa(e_core_opa), .core_opb(e_core_opb), .core_rmode(e_core_rmode), .core_en(e_core_en),
        .core_Sz(e_core_Sz), .core_Ez(e_core_Ez), .core_Mz(e_core_Mz), .core_flags(5'b00000),
        .res_valid(e_res_valid), .res_ready(1'b1), .res_z(e_res_z), .res_id(e_res_id),
        .res_flags(e_res_flags), .sticky_flags(e_sticky), .flag_clr(1'b0)
    );

    // Truncating single-precision multiply for normal operands: {sign, exp, 24-bit mantissa}.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [7:0]  e;
        logic [23:0] m;
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        if (p[47]) begin
            m = p[47:24];
            e = a[30:23] + b[30:23] - 8'd126;
        end else begin
            m = p[46:23];
            e = a[30:23] + b[30:23] - 8'd127;
        end
        return {a[31] ^ b[31], e, m};
    endfunction

    function automatic logic [31:0] exp_z(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = fmul(a, b);
        return {r[32:24], r[22:0]};
    endfunction

    always_comb {core_Sz, core_Ez, core_Mz} = fmul(core_opa, core_opb);
    always_comb {e_core_Sz, e_core_Ez, e_core_Mz} = fmul(e_core_opa, e_core_opb);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic clr);
        int n;
        res_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check_eq("op_grant_in_time", 32'(n < 20), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (LAT - 1) tick();
        flag_clr = clr;
        tick();
        flag_clr = 1'b0;
        check_eq("op_res_valid", 32'(res_valid), 32'd1);
        tick();
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, exp_z(req0_a, req0_b), core_flags});
                acc_q.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, exp_z(req1_a, req1_b), core_flags});
                acc_q.push_back(1'b1);
            end
            if (req0_ready && req1_ready) check_eq("one_grant_only", 32'd1, 32'd0);
            if (res_valid && res_ready) begin
                done_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_result", 32'(sb.size()), 32'd1);
                end else begin
                    sb_entry_t x;
                    x = sb.pop_front();
                    check_eq("sb_z", res_z, x.z);
                    check_eq("sb_id", 32'(res_id), 32'(x.id));
                    check_eq("sb_flags", 32'(res_flags), 32'(x.fl));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [31:0] hold_z;
        rst_n = 1'b0; flag_clr = 1'b0; res_ready = 1'b0; core_flags = 5'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_rmode = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_rmode = '0;
        e_req0_valid = 1'b0; e_req0_a = '0; e_req0_b = '0;
        repeat (2) tick();

        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_z", res_z, 32'd0);
        check_eq("rst_sticky", 32'(sticky_flags), 32'd0);
        check_eq("rst_core_opa", core_opa, 32'd0);
        check_eq("rst_core_en", 32'(core_en), 32'd0);
        rst_n = 1'b1;

        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rmode = 2'd0;
        #1;
        check_eq("single_ready0", 32'(req0_ready), 32'd1);
        check_eq("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req0_a = 32'hDEADBEEF;
        check_eq("single_opa", core_opa, 32'h3FC00000);
        check_eq("single_opb", core_opb, 32'h40000000);
        check_eq("single_en_c1", 32'(core_en), 32'd1);
        check_eq("single_valid_c1", 32'(res_valid), 32'd0);
        tick();
        check_eq("single_en_c2", 32'(core_en), 32'd1);
        check_eq("single_valid_c2", 32'(res_valid), 32'd0);
        tick();
        check_eq("single_valid_c3", 32'(res_valid), 32'd1);
        check_eq("single_z", res_z, 32'h40400000);
        check_eq("single_id", 32'(res_id), 32'd0);
        check_eq("single_flags", 32'(res_flags), 32'd0);
        check_eq("single_en_c3", 32'(core_en), 32'd0);

        hold_z = res_z;
        req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40400000; req1_rmode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_ready0", 32'(req0_ready), 32'd0);
            check_eq("bp_ready1", 32'(req1_ready), 32'd0);
            check_eq("bp_valid", 32'(res_valid), 32'd1);
            check_eq("bp_z_stable", res_z, hold_z);
            check_eq("bp_id_stable", 32'(res_id), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check_eq("bp_no_accept_in_hs", 32'(req1_ready), 32'd0);
        tick();
        check_eq("bp_valid_dropped", 32'(res_valid), 32'd0);
        check_eq("bp_accept_after_hs", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_eq("bp_rmode", 32'(core_rmode), 32'd3);
        repeat (LAT + 3) tick();
        check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        acc_q.delete(); done_cyc.delete();
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000;
        req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40400000;
        repeat (17) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 4) tick();
        check_eq("rr_count", 32'(acc_q.size() >= 4), 32'd1);
        if (acc_q.size() >= 4)
            for (int i = 0; i < 4; i++) check_eq("rr_grant_order", 32'(acc_q[i]), 32'(i % 2));
        if (done_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) check_eq("rr_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'(LAT + 2));
        check_eq("rr_sb_empty", 32'(sb.size()), 32'd0);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        core_flags = 5'b01010;
        do_op(1'b0, 32'h3FC00000, 32'h40000000, 1'b0);
        core_flags = 5'b00001;
        do_op(1'b1, 32'h40400000, 32'h40000000, 1'b0);
        check_eq("sticky_or", 32'(sticky_flags), 32'h0B);
        core_flags = 5'b00100;
        do_op(1'b0, 32'h40400000, 32'h40400000, 1'b1);
        check_eq("sticky_clr_vs_new", 32'(sticky_flags), 32'h04);
        core_flags = 5'b00000;

        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rmode = 2'd2;
        #1;
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
        check_eq("mid_rst_z", res_z, 32'd0);
        check_eq("mid_rst_id", 32'(res_id), 32'd0);
        check_eq("mid_rst_flags", 32'(res_flags), 32'd0);
        check_eq("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        check_eq("mid_rst_opa", core_opa, 32'd0);
        check_eq("mid_rst_opb", core_opb, 32'd0);
        check_eq("mid_rst_rmode", 32'(core_rmode), 32'd0);
        check_eq("mid_rst_en", 32'(core_en), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | res_valid;
        end
        check_eq("mid_rst_no_result", 32'(seen), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("mid_rst_ptr0", 32'(req0_ready), 32'd1);
        check_eq("mid_rst_ptr1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();

        e_req0_valid = 1'b1; e_req0_a = 32'h40400000; e_req0_b = 32'h40000000;
        #1;
        check_eq("lat1_ready", 32'(e_req0_ready), 32'd1);
        tick();
        e_req0_valid = 1'b0;
        check_eq("lat1_en_c1", 32'(e_core_en), 32'd1);
        check_eq("lat1_valid_c1", 32'(e_res_valid), 32'd0);
        tick();
        check_eq("lat1_valid_c2", 32'(e_res_valid), 32'd1);
        check_eq("lat1_en_c2", 32'(e_core_en), 32'd0);
        check_eq("lat1_z", e_res_z, 32'h40C00000);
        tick();
        check_eq("lat1_valid_c3", 32'(e_res_valid), 32'd0);

        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
